usbfs_rx_transaction_ctrl: RTL and testbench

//  Transaction-level sequencer behind the USB FS packet receiver. Consumes parsed packets (PID/addr/bytes/fin/okay),

---
 rtl/usbfs_rx_transaction_ctrl_if.sv | 35 +++
 rtl/usbfs_rx_transaction_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_usbfs_rx_transaction_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/usbfs_rx_transaction_ctrl_if.sv
// Packet-receiver to transaction-controller bus: parsed packet fields in, payload/handshake/IN requests out.
// The master is the packet side, which drives rp_*. The slave is the transaction controller.
interface usbfs_rx_transaction_ctrl_if;
  logic [3:0]  rp_pid;
  logic [10:0] rp_addr;
  logic        rp_byte_en;
  logic [7:0]  rp_byte;
  logic        rp_fin;
  logic        rp_okay;
  logic        out_byte_en;
  logic [7:0]  out_byte;
  logic [3:0]  out_ep;
  logic        out_setup;
  logic        out_commit;
  logic        out_abort;
  logic        in_req;
  logic [3:0]  in_ep;
  logic        in_data1;
  logic        in_ack;
  logic        hs_req;
  logic [3:0]  hs_pid;
  logic        sof_en;
  logic [10:0] sof_frame;

  modport master (
    output rp_pid, rp_addr, rp_byte_en, rp_byte, rp_fin, rp_okay,
    input  out_byte_en, out_byte, out_ep, out_setup, out_commit, out_abort,
           in_req, in_ep, in_data1, in_ack, hs_req, hs_pid, sof_en, sof_frame
  );
  modport slave (
    input  rp_pid, rp_addr, rp_byte_en, rp_byte, rp_fin, rp_okay,
    output out_byte_en, out_byte, out_ep, out_setup, out_commit, out_abort,
           in_req, in_ep, in_data1, in_ack, hs_req, hs_pid, sof_en, sof_frame
  );
endinterface

// File: rtl/usbfs_rx_transaction_ctrl.sv
// USB FS transaction sequencer: token match, CRC16 strip, per-endpoint data toggles, handshake/IN requests.
// Optional USBFS_EP_STALL_EN adds the ep_stall input and STALL handshakes.
module usbfs_rx_transaction_ctrl #(
  parameter int NUM_EP      = 4,
  parameter int MAX_PKT     = 64,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        dev_addr,
  input  logic [NUM_EP-1:0] ep_out_ready,
  input  logic [NUM_EP-1:0] ep_in_valid,
`ifdef USBFS_EP_STALL_EN
  input  logic [NUM_EP-1:0] ep_stall,
`endif
  usbfs_rx_transaction_ctrl_if.slave pkt
);
  localparam int EW = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam int CW = $clog2(MAX_PKT + 4);
  localparam logic [4:0] NEP = 5'(NUM_EP);

  typedef enum logic [1:0] {IDLE, DATA_WAIT, IN_WAIT} state_t;
  state_t state_q, state_d;

  logic [TW-1:0]     timer_q, timer_d;
  logic [3:0]        ep_q, ep_d;
  logic              ready_q, ready_d, setup_q, setup_d, stall_q, stall_d;
  logic [NUM_EP-1:0] out_tog_q, out_tog_d, in_tog_q, in_tog_d, stall_v;
  logic              commit_d, abort_d, in_req_d, in_d1_d, in_ack_d, hs_req_d, clr_dp;
  logic [3:0]        hs_pid_d;
  logic [CW-1:0]     cnt_q;
  logic              ovf_q;
  logic [1:0][7:0]   dly_q;

`ifdef USBFS_EP_STALL_EN
  assign stall_v = ep_stall;
`else
  assign stall_v = '0;
`endif

  logic          pkt_ok, is_sof, is_tok, tok_match, is_data, timeout;
  logic [3:0]    tok_ep;
  logic [EW-1:0] tok_idx, ep_idx;

  assign pkt_ok    = pkt.rp_fin & pkt.rp_okay;
  assign is_sof    = pkt_ok & (pkt.rp_pid == 4'h5);
  assign is_tok    = pkt_ok & (pkt.rp_pid[1:0] == 2'b01) & (pkt.rp_pid != 4'h5);
  assign tok_ep    = pkt.rp_addr[10:7];
  assign tok_idx   = tok_ep[EW-1:0];
  assign ep_idx    = ep_q[EW-1:0];
  assign tok_match = is_tok & (pkt.rp_addr[6:0] == dev_addr) & ({1'b0, tok_ep} < NEP);
  assign is_data   = pkt.rp_fin & ((pkt.rp_pid == 4'h3) | (pkt.rp_pid == 4'hB));
  assign timeout   = (timer_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d   = state_q;
    timer_d   = (state_q != IDLE) ? timer_q + 1'b1 : '0;
    ep_d      = ep_q;
    ready_d   = ready_q;
    setup_d   = setup_q;
    stall_d   = stall_q;
    out_tog_d = out_tog_q;
    in_tog_d  = in_tog_q;
    commit_d  = 1'b0;
    abort_d   = 1'b0;
    in_req_d  = 1'b0;
    in_d1_d   = 1'b0;
    in_ack_d  = 1'b0;
    hs_req_d  = 1'b0;
    hs_pid_d  = 4'h0;
    clr_dp    = 1'b0;

    case (state_q)
      DATA_WAIT: begin
        if (is_data) begin
          state_d = IDLE;
          if (!pkt.rp_okay || ovf_q) begin
            abort_d = 1'b1;
          end else if (!ready_q) begin
            abort_d  = 1'b1;
            hs_req_d = 1'b1;
            hs_pid_d = stall_q ? 4'hE : 4'hA;
          end else if (pkt.rp_pid[3] == out_tog_q[ep_idx]) begin
            commit_d  = 1'b1;
            hs_req_d  = 1'b1;
            hs_pid_d  = 4'h2;
            out_tog_d[ep_idx] = ~out_tog_q[ep_idx];
          end else begin
            // Host missed our ACK and resent: ack again but drop the duplicate.
            abort_d  = 1'b1;
            hs_req_d = 1'b1;
            hs_pid_d = 4'h2;
          end
        end else if (timeout) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end
      end
      IN_WAIT: begin
        if (pkt_ok && pkt.rp_pid == 4'h2) begin
          state_d  = IDLE;
          in_ack_d = 1'b1;
          in_tog_d[ep_idx] = ~in_tog_q[ep_idx];
        end else if ((pkt.rp_fin && pkt.rp_pid != 4'h5) || timeout) begin
          state_d = IDLE;
        end
      end
      default: ;
    endcase

    // Any new token ends the pending transaction and is handled in the same cycle.
    if (is_tok) begin
      if (state_q == DATA_WAIT) abort_d = 1'b1;
      state_d = IDLE;
      timer_d = '0;
      if (tok_match) begin
        if (pkt.rp_pid == 4'h1 || pkt.rp_pid == 4'hD) begin
          ep_d    = tok_ep;
          setup_d = (pkt.rp_pid == 4'hD);
          stall_d = !setup_d && stall_v[tok_idx];
          ready_d = setup_d || (ep_out_ready[tok_idx] && !stall_v[tok_idx]);
          if (setup_d) begin
            out_tog_d[tok_idx] = 1'b0;
            in_tog_d[tok_idx]  = 1'b1;
          end
          state_d = DATA_WAIT;
          clr_dp  = 1'b1;
        end else if (pkt.rp_pid == 4'h9) begin
          ep_d    = tok_ep;
          setup_d = 1'b0;
          if (stall_v[tok_idx]) begin
            hs_req_d = 1'b1;
            hs_pid_d = 4'hE;
          end else if (ep_in_valid[tok_idx]) begin
            in_req_d = 1'b1;
            in_d1_d  = in_tog_q[tok_idx];
            state_d  = IN_WAIT;
          end else begin
            hs_req_d = 1'b1;
            hs_pid_d = 4'hA;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      ep_q           <= '0;
      ready_q        <= 1'b0;
      setup_q        <= 1'b0;
      stall_q        <= 1'b0;
      out_tog_q      <= '0;
      in_tog_q       <= '0;
      pkt.out_commit <= 1'b0;
      pkt.out_abort  <= 1'b0;
      pkt.in_req     <= 1'b0;
      pkt.in_data1   <= 1'b0;
      pkt.in_ack     <= 1'b0;
      pkt.hs_req     <= 1'b0;
      pkt.hs_pid     <= 4'h0;
      pkt.sof_en     <= 1'b0;
      pkt.sof_frame  <= '0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      ep_q           <= ep_d;
      ready_q        <= ready_d;
      setup_q        <= setup_d;
      stall_q        <= stall_d;
      out_tog_q      <= out_tog_d;
      in_tog_q       <= in_tog_d;
      pkt.out_commit <= commit_d;
      pkt.out_abort  <= abort_d;
      pkt.in_req     <= in_req_d;
      pkt.in_data1   <= in_d1_d;
      pkt.in_ack     <= in_ack_d;
      pkt.hs_req     <= hs_req_d;
      pkt.hs_pid     <= hs_pid_d;
      pkt.sof_en     <= is_sof;
      if (is_sof) pkt.sof_frame <= pkt.rp_addr;
    end
  end

  // Two-byte delay line: the last two bytes of a data packet are CRC16 and never leave.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q           <= '0;
      ovf_q           <= 1'b0;
      dly_q           <= '0;
      pkt.out_byte_en <= 1'b0;
      pkt.out_byte    <= 8'h00;
    end else begin
      pkt.out_byte_en <= 1'b0;
      if (clr_dp) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else if (state_q == DATA_WAIT && pkt.rp_byte_en) begin
        dly_q           <= {dly_q[0], pkt.rp_byte};
        pkt.out_byte    <= dly_q[1];
        pkt.out_byte_en <= ready_q && (cnt_q >= CW'(2)) && (cnt_q < CW'(MAX_PKT + 2));
        if (cnt_q != CW'(MAX_PKT + 3)) cnt_q <= cnt_q + 1'b1;
        if (cnt_q >= CW'(MAX_PKT + 2)) ovf_q <= 1'b1;
      end
    end
  end

  assign pkt.out_ep    = ep_q;
  assign pkt.in_ep     = ep_q;
  assign pkt.out_setup = setup_q;
endmodule

// File: tb/tb_usbfs_rx_transaction_ctrl.sv
// Directed bench for usbfs_rx_transaction_ctrl: drives parsed packets, counts output pulses on the falling edge.
module tb_usbfs_rx_transaction_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] dev_addr = 7'h2A;
  logic [3:0] ep_out_ready = 4'hF;
  logic [3:0] ep_in_valid  = 4'b0101;
`ifdef USBFS_EP_STALL_EN
  logic [3:0] ep_stall = 4'h0;
`endif

  usbfs_rx_transaction_ctrl_if bus();

  usbfs_rx_transaction_ctrl #(.NUM_EP(4), .MAX_PKT(64), .TIMEOUT_CYC(1024)) dut (
    .clk(clk), .rst(rst), .dev_addr(dev_addr),
    .ep_out_ready(ep_out_ready), .ep_in_valid(ep_in_valid),
`ifdef USBFS_EP_STALL_EN
    .ep_stall(ep_stall),
`endif
    .pkt(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int n_commit = 0, n_abort = 0, n_hs = 0, n_inreq = 0, n_inack = 0, n_sof = 0;
  logic [3:0]  last_hs_pid = '0, last_in_ep = '0;
  logic        last_in_d1 = 1'b0;
  logic [10:0] last_frame = '0;
  logic [7:0]  got[$];
  int b_commit, b_abort, b_hs, b_inreq, b_inack, b_sof, b_bytes;

  always @(negedge clk) begin
    if (bus.out_byte_en) got.push_back(bus.out_byte);
    if (bus.out_commit)  n_commit++;
    if (bus.out_abort)   n_abort++;
    if (bus.hs_req)      begin n_hs++; last_hs_pid = bus.hs_pid; end
    if (bus.in_req)      begin n_inreq++; last_in_d1 = bus.in_data1; last_in_ep = bus.in_ep; end
    if (bus.in_ack)      n_inack++;
    if (bus.sof_en)      begin n_sof++; last_frame = bus.sof_frame; end
  end

  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_chk++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  task automatic mark();
    b_commit = n_commit; b_abort = n_abort; b_hs = n_hs;
    b_inreq = n_inreq; b_inack = n_inack; b_sof = n_sof; b_bytes = got.size();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Single-cycle packet with no data phase (token, SOF, handshake).
  task automatic short_pkt(input logic [3:0] pid, input logic [3:0] ep, input logic [6:0] addr);
    @(negedge clk);
    bus.rp_pid = pid; bus.rp_addr = {ep, addr}; bus.rp_fin = 1'b1; bus.rp_okay = 1'b1;
    @(negedge clk);
    bus.rp_fin = 1'b0; bus.rp_okay = 1'b0;
  endtask

  // Payload byte i is 0x10+i, then two CRC bytes, then the end-of-packet pulse.
  task automatic data_pkt(input logic [3:0] pid, input int n, input logic okay);
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      bus.rp_byte_en = 1'b1;
      bus.rp_byte    = (i < n) ? 8'((16 + i) & 255) : 8'hC5;
    end
    @(negedge clk);
    bus.rp_byte_en = 1'b0;
    @(negedge clk);
    bus.rp_pid = pid; bus.rp_fin = 1'b1; bus.rp_okay = okay;
    @(negedge clk);
    bus.rp_fin = 1'b0; bus.rp_okay = 1'b0;
    idle(3);
  endtask

  initial begin
    bus.rp_pid = '0; bus.rp_addr = '0; bus.rp_byte_en = 1'b0;
    bus.rp_byte = '0; bus.rp_fin = 1'b0; bus.rp_okay = 1'b0;
    idle(3);
    chk("reset_outputs", 32'({bus.out_byte_en, bus.out_commit, bus.out_abort, bus.in_req, bus.in_ack,
        bus.hs_req, bus.hs_pid, bus.sof_en, bus.out_ep, bus.in_data1, bus.out_setup}), 32'h0);
    rst = 1'b0;
    idle(2);

    // OUT ep1 DATA0, 3 bytes: streamed and committed, toggle1 -> 1
    mark(); short_pkt(4'h1, 4'd1, 7'h2A); data_pkt(4'h3, 3, 1'b1);
    chk("out1_bytes", got.size() - b_bytes, 3);
    chk("out1_b0", got[b_bytes], 8'h10);
    chk("out1_b2", got[b_bytes + 2], 8'h12);
    chk("out1_commit", n_commit - b_commit, 1);
    chk("out1_abort", n_abort - b_abort, 0);
    chk("out1_hs", {28'(n_hs - b_hs), last_hs_pid}, {28'd1, 4'h2});
    chk("out1_ep", {bus.out_setup, bus.out_ep}, {1'b0, 4'd1});

    // Same DATA0 again is a retry: ack, drop
    mark(); short_pkt(4'h1, 4'd1, 7'h2A); data_pkt(4'h3, 3, 1'b1);
    chk("retry_abort", {n_commit - b_commit, n_abort - b_abort}, {32'd0, 32'd1});
    chk("retry_hs", {28'(n_hs - b_hs), last_hs_pid}, {28'd1, 4'h2});
    // DATA1 now matches toggle1=1, proving the retry did not flip
    mark(); short_pkt(4'h1, 4'd1, 7'h2A); data_pkt(4'hB, 2, 1'b1);
    chk("data1_commit", n_commit - b_commit, 1);

    // ep1 not ready -> NAK, nothing streamed
    ep_out_ready = 4'b1101;
    mark(); short_pkt(4'h1, 4'd1, 7'h2A); data_pkt(4'h3, 3, 1'b1);
    chk("nak_hs", {28'(n_hs - b_hs), last_hs_pid}, {28'd1, 4'hA});
    chk("nak_abort", n_abort - b_abort, 1);
    chk("nak_bytes", got.size() - b_bytes, 0);

    // SETUP ep0 with ep not ready, bad CRC -> abort, no handshake
    ep_out_ready = 4'b0000;
    mark(); short_pkt(4'hD, 4'd0, 7'h2A); data_pkt(4'h3, 8, 1'b0);
    chk("setup_bad_abort", n_abort - b_abort, 1);
    chk("setup_bad_hs", n_hs - b_hs, 0);
    mark(); short_pkt(4'hD, 4'd0, 7'h2A); data_pkt(4'h3, 8, 1'b1);
    chk("setup_commit", n_commit - b_commit, 1);
    chk("setup_bytes", got.size() - b_bytes, 8);
    chk("setup_flag", {bus.out_setup, bus.out_ep}, {1'b1, 4'd0});
    mark(); short_pkt(4'h9, 4'd0, 7'h2A); idle(2);
    chk("in0_after_setup", {28'(n_inreq - b_inreq), 3'd0, last_in_d1}, {28'd1, 4'd1});

    // IN ep2: DATA0, ack flips, timeout does not
    ep_out_ready = 4'b1101;
    mark(); short_pkt(4'h9, 4'd2, 7'h2A); idle(2);
    chk("in2_req", {24'(n_inreq - b_inreq), last_in_ep, 3'd0, last_in_d1}, {24'd1, 4'd2, 4'd0});
    mark(); short_pkt(4'h2, 4'd0, 7'h00); idle(2);
    chk("in2_ack", n_inack - b_inack, 1);
    mark(); short_pkt(4'h9, 4'd2, 7'h2A); idle(2);
    chk("in2_toggled", {3'd0, last_in_d1}, 4'd1);
    idle(1030);
    mark(); short_pkt(4'h2, 4'd0, 7'h00); idle(2);
    chk("in2_timeout_noack", n_inack - b_inack, 0);
    mark(); short_pkt(4'h9, 4'd2, 7'h2A); idle(2);
    chk("in2_noflip", {28'(n_inreq - b_inreq), 3'd0, last_in_d1}, {28'd1, 4'd1});
    mark(); short_pkt(4'h9, 4'd3, 7'h2A); idle(2);
    chk("in3_nak", {28'(n_hs - b_hs + n_inreq - b_inreq), last_hs_pid}, {28'd1, 4'hA});

    // Unmatched tokens produce nothing
    mark(); short_pkt(4'h1, 4'd1, 7'h2B); data_pkt(4'h3, 3, 1'b1);
    short_pkt(4'h1, 4'd4, 7'h2A); data_pkt(4'h3, 3, 1'b1);
    short_pkt(4'h9, 4'd4, 7'h2A); idle(2);
    chk("unmatched", (n_commit - b_commit) + (n_abort - b_abort) + (n_hs - b_hs)
        + (n_inreq - b_inreq) + (got.size() - b_bytes), 0);

    // SOF in the middle of an OUT transaction
    mark(); short_pkt(4'h1, 4'd2, 7'h2A); short_pkt(4'h5, 4'hF, 7'h7F); data_pkt(4'h3, 2, 1'b1);
    chk("sof", {21'(n_sof - b_sof), last_frame}, {21'd1, 11'h7FF});
    chk("sof_keeps_out", n_commit - b_commit, 1);

    // 66-byte payload: 64 streamed, overflow abort, no handshake
    mark(); short_pkt(4'h1, 4'd2, 7'h2A); data_pkt(4'hB, 66, 1'b1);
    chk("ovf_bytes", got.size() - b_bytes, 64);
    chk("ovf_last", got[got.size() - 1], 8'h4F);
    chk("ovf_result", {n_commit - b_commit, n_abort - b_abort, n_hs - b_hs}, {32'd0, 32'd1, 32'd0});

    // Zero-length DATA1 commits
    mark(); short_pkt(4'h1, 4'd2, 7'h2A); data_pkt(4'hB, 0, 1'b1);
    chk("zlp", {n_commit - b_commit, 32'(got.size() - b_bytes)}, {32'd1, 32'd0});

    // OUT token then silence -> timeout abort
    mark(); short_pkt(4'h1, 4'd2, 7'h2A); idle(1030);
    chk("out_timeout", {n_abort - b_abort, n_hs - b_hs}, {32'd1, 32'd0});

    // Reset mid-payload
    ep_out_ready = 4'hF;
    short_pkt(4'h1, 4'd0, 7'h2A);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); bus.rp_byte_en = 1'b1; bus.rp_byte = 8'(i);
    end
    mark();
    @(negedge clk); rst = 1'b1; bus.rp_byte_en = 1'b0;
    #1;
    chk("rst_mid_outputs", 32'({bus.out_byte_en, bus.out_commit, bus.out_abort, bus.in_req, bus.in_ack,
        bus.hs_req, bus.hs_pid, bus.sof_en, bus.out_ep, bus.in_data1, bus.out_setup}), 32'h0);
    idle(3); rst = 1'b0; idle(3);
    chk("rst_no_pulses", (n_commit - b_commit) + (n_abort - b_abort) + (n_hs - b_hs), 0);
    // toggles back to 0: ep0 (was 1) accepts DATA0, ep2 IN (was 1) sends DATA0
    mark(); short_pkt(4'h1, 4'd0, 7'h2A); data_pkt(4'h3, 1, 1'b1);
    chk("rst_out_tog", n_commit - b_commit, 1);
    mark(); short_pkt(4'h9, 4'd2, 7'h2A); idle(2);
    chk("rst_in_tog", {28'(n_inreq - b_inreq), 3'd0, last_in_d1}, {28'd1, 4'd0});

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
